// File: rtl/laser_scan_ctrl.sv
// Sequencing controller for the two-circle laser coverage search: raster-scans
// candidate centres into an external count engine and keeps the best centres.
`timescale 1ns/1ps
module laser_scan_ctrl #(
    parameter int WIN      = 3,
    parameter int MAX_ITER = 3,
    parameter int CW       = 6
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic          BUSY,
    output logic          REQ,
    input  logic          ACK,
    input  logic [CW-1:0] CNT,
    output logic          SEL,
    output logic [3:0]    CAND_X,
    output logic [3:0]    CAND_Y,
    output logic [3:0]    FIX_X,
    output logic [3:0]    FIX_Y,
    output logic          FIX_EN,
    output logic [3:0]    C1X,
    output logic [3:0]    C1Y,
    output logic [3:0]    C2X,
    output logic [3:0]    C2Y,
    output logic [CW-1:0] BEST,
    output logic          DONE
);

    localparam int IW = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(MAX_ITER);
    localparam logic signed [5:0] WIN_S = 6'(WIN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREP     = 3'd1;
    localparam logic [2:0] S_REQ      = 3'd2;
    localparam logic [2:0] S_STEP     = 3'd3;
    localparam logic [2:0] S_PASS_END = 3'd4;
    localparam logic [2:0] S_FIN      = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          sel_q, sel_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [3:0]    cand_x_q, cand_x_d;
    logic [3:0]    cand_y_q, cand_y_d;
    logic [3:0]    lo_x_q, lo_x_d;
    logic [3:0]    lo_y_q, lo_y_d;
    logic [3:0]    hi_x_q, hi_x_d;
    logic [3:0]    hi_y_q, hi_y_d;
    logic          pb_valid_q, pb_valid_d;
    logic [CW-1:0] pb_cnt_q, pb_cnt_d;
    logic [3:0]    pb_x_q, pb_x_d;
    logic [3:0]    pb_y_q, pb_y_d;
    logic [3:0]    c1x_q, c1x_d;
    logic [3:0]    c1y_q, c1y_d;
    logic [3:0]    c2x_q, c2x_d;
    logic [3:0]    c2y_q, c2y_d;
    logic [CW-1:0] best_q, best_d;
    logic [CW-1:0] b0_q, b0_d;

    // Window around the moving circle's best centre; index 0 = x, 1 = y.
    logic [3:0] mov_c  [2];
    logic [3:0] win_lo [2];
    logic [3:0] win_hi [2];

    assign mov_c[0] = sel_q ? c2x_q : c1x_q;
    assign mov_c[1] = sel_q ? c2y_q : c1y_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_win
            // One bit wider than 5-bit signed so c+WIN near 15 cannot overflow.
            logic signed [5:0] c_s;
            logic signed [5:0] lo_s;
            logic signed [5:0] hi_s;
            assign c_s  = $signed({2'b00, mov_c[gi]});
            assign lo_s = c_s - WIN_S;
            assign hi_s = c_s + WIN_S;
            assign win_lo[gi] = (iter_q == '0)     ? 4'd0  :
                                (lo_s < 6'sd0)     ? 4'd0  : lo_s[3:0];
            assign win_hi[gi] = (iter_q == '0)     ? 4'd15 :
                                (hi_s > 6'sd15)    ? 4'd15 : hi_s[3:0];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        iter_d     = iter_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        lo_x_d     = lo_x_q;
        lo_y_d     = lo_y_q;
        hi_x_d     = hi_x_q;
        hi_y_d     = hi_y_q;
        pb_valid_d = pb_valid_q;
        pb_cnt_d   = pb_cnt_q;
        pb_x_d     = pb_x_q;
        pb_y_d     = pb_y_q;
        c1x_d      = c1x_q;
        c1y_d      = c1y_q;
        c2x_d      = c2x_q;
        c2y_d      = c2y_q;
        best_d     = best_q;
        b0_d       = b0_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    c1x_d   = '0;
                    c1y_d   = '0;
                    c2x_d   = '0;
                    c2y_d   = '0;
                    best_d  = '0;
                    b0_d    = '0;
                    iter_d  = '0;
                    sel_d   = 1'b0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                lo_x_d     = win_lo[0];
                lo_y_d     = win_lo[1];
                hi_x_d     = win_hi[0];
                hi_y_d     = win_hi[1];
                cand_x_d   = win_lo[0];
                cand_y_d   = win_lo[1];
                pb_valid_d = 1'b0;
                state_d    = S_REQ;
            end
            S_REQ: begin
                if (ACK) begin
                    // Strict compare keeps the earliest candidate on a tie.
                    if (!pb_valid_q || (CNT > pb_cnt_q)) begin
                        pb_cnt_d = CNT;
                        pb_x_d   = cand_x_q;
                        pb_y_d   = cand_y_q;
                    end
                    pb_valid_d = 1'b1;
                    state_d    = S_STEP;
                end
            end
            S_STEP: begin
                state_d = S_REQ;
                if (cand_x_q == hi_x_q) begin
                    if (cand_y_q == hi_y_q) begin
                        state_d = S_PASS_END;
                    end else begin
                        cand_x_d = lo_x_q;
                        cand_y_d = cand_y_q + 4'd1;
                    end
                end else begin
                    cand_x_d = cand_x_q + 4'd1;
                end
            end
            S_PASS_END: begin
                best_d = pb_cnt_q;
                if (!sel_q) begin
                    c1x_d   = pb_x_q;
                    c1y_d   = pb_y_q;
                    sel_d   = 1'b1;
                    state_d = S_PREP;
                end else begin
                    c2x_d = pb_x_q;
                    c2y_d = pb_y_q;
                    if ((iter_q == ITER_LAST) ||
                        ((iter_q != '0) && (pb_cnt_q <= b0_q))) begin
                        state_d = S_FIN;
                    end else begin
                        iter_d  = iter_q + IW'(1);
                        sel_d   = 1'b0;
                        b0_d    = pb_cnt_q;
                        state_d = S_PREP;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            iter_q     <= '0;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            lo_x_q     <= '0;
            lo_y_q     <= '0;
            hi_x_q     <= '0;
            hi_y_q     <= '0;
            pb_valid_q <= 1'b0;
            pb_cnt_q   <= '0;
            pb_x_q     <= '0;
            pb_y_q     <= '0;
            c1x_q      <= '0;
            c1y_q      <= '0;
            c2x_q      <= '0;
            c2y_q      <= '0;
            best_q     <= '0;
            b0_q       <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            iter_q     <= iter_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            lo_x_q     <= lo_x_d;
            lo_y_q     <= lo_y_d;
            hi_x_q     <= hi_x_d;
            hi_y_q     <= hi_y_d;
            pb_valid_q <= pb_valid_d;
            pb_cnt_q   <= pb_cnt_d;
            pb_x_q     <= pb_x_d;
            pb_y_q     <= pb_y_d;
            c1x_q      <= c1x_d;
            c1y_q      <= c1y_d;
            c2x_q      <= c2x_d;
            c2y_q      <= c2y_d;
            best_q     <= best_d;
            b0_q       <= b0_d;
        end
    end

    assign BUSY   = (state_q != S_IDLE);
    assign REQ    = (state_q == S_REQ);
    assign DONE   = (state_q == S_FIN);
    assign SEL    = sel_q;
    assign CAND_X = cand_x_q;
    assign CAND_Y = cand_y_q;
    assign FIX_X  = sel_q ? c1x_q : c2x_q;
    assign FIX_Y  = sel_q ? c1y_q : c2y_q;
    // Circle 1 is scored alone only in the very first pass.
    assign FIX_EN = BUSY && !((iter_q == '0) && !sel_q);
    assign C1X    = c1x_q;
    assign C1Y    = c1y_q;
    assign C2X    = c2x_q;
    assign C2Y    = c2y_q;
    assign BEST   = best_q;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Bench for laser_scan_ctrl: stub count engine, table of search scenarios with a
// result scoreboard, plus hand sequences for async reset and timeline checks.
`timescale 1ns/1ps
module tb_laser_scan_ctrl;

    localparam int CW = 6;

    logic          CLK;
    logic          RST;
    logic          START;
    logic          BUSY;
    logic          REQ;
    logic          ACK;
    logic [CW-1:0] CNT;
    logic          SEL;
    logic [3:0]    CAND_X, CAND_Y, FIX_X, FIX_Y;
    logic          FIX_EN;
    logic [3:0]    C1X, C1Y, C2X, C2Y;
    logic [CW-1:0] BEST;
    logic          DONE;

    laser_scan_ctrl #(.WIN(3), .MAX_ITER(3), .CW(CW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .REQ(REQ),
        .ACK(ACK), .CNT(CNT), .SEL(SEL), .CAND_X(CAND_X), .CAND_Y(CAND_Y),
        .FIX_X(FIX_X), .FIX_Y(FIX_Y), .FIX_EN(FIX_EN), .C1X(C1X), .C1Y(C1Y),
        .C2X(C2X), .C2Y(C2Y), .BEST(BEST), .DONE(DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int mode;
        int dly;
        int spur;
        int c1x;
        int c1y;
        int c2x;
        int c2y;
        int best;
        int acks;
        int passes;
    } vec_t;

    vec_t vecs[6];
    vec_t sb_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Engine stub configuration and per-run statistics.
    int   eng_mode = 0;
    int   eng_dly  = 0;
    int   eng_spur = 0;
    int   acks, passes, gap1, gap3, gapx, low_run;
    bit   seen_req, prev_req;
    logic last_sel;
    int   pcnt[16], pfx[16], pfy[16], plx[16], ply[16];
    int   pxx[16], pxy[16], pxe[16];

    function automatic int stub(input int mode, input int sel, input int x,
                                input int y, input int k);
        case (mode)
            0: return 0;
            1: begin
                if (sel == 0 && x == 7 && y == 9) return 20;
                if (sel == 1 && x == 3 && y == 12) return 30;
                return 1;
            end
            2: return (sel == 0 && ((x == 2 && y == 2) || (x == 9 && y == 9))) ? 5 : 0;
            default: return 10 * k + sel + 1;
        endcase
    endfunction

    function automatic int hold_key();
        return {14'd0, CAND_X, CAND_Y, SEL, FIX_X, FIX_Y, FIX_EN};
    endfunction

    task automatic clear_stats();
        acks = 0; passes = 0; gap1 = 0; gap3 = 0; gapx = 0;
        low_run = 0; seen_req = 0; prev_req = 0; last_sel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pcnt[i] = 0; pfx[i] = 0; pfy[i] = 0; plx[i] = 0; ply[i] = 0;
            pxx[i] = 0; pxy[i] = 0; pxe[i] = 0;
        end
    endtask

    // Stub engine: answers each REQ after a chosen delay, checks the handshake.
    initial begin
        bit have;
        bit real_ack;
        bit skip;
        int wait_left;
        int hkey;
        int cur;
        have = 0; real_ack = 0; wait_left = 0; hkey = 0;
        ACK = 1'b0;
        CNT = '0;
        forever begin
            @(negedge CLK);
            skip = 0;
            if (REQ) begin
                if (!prev_req && seen_req) begin
                    if (low_run == 1) gap1++;
                    else if (low_run == 3) gap3++;
                    else gapx++;
                end
                seen_req = 1;
                low_run  = 0;
            end else if (seen_req) begin
                low_run++;
            end
            prev_req = REQ;

            if (ACK) begin
                ACK = 1'b0;
                CNT = '0;
                if (real_ack) begin
                    real_ack = 0;
                    chk("req_fall", REQ, 0);
                    skip = 1;
                end
            end
            if (!skip) begin
                if (REQ) begin
                    if (!have) begin
                        have = 1;
                        hkey = hold_key();
                        wait_left = (eng_dly == 0) ? 0 :
                                    (eng_dly == 1) ? 5 : $urandom_range(0, 7);
                    end else begin
                        chk("req_hold", hold_key(), hkey);
                    end
                    if (wait_left == 0) begin
                        have = 0;
                        real_ack = 1;
                        if (acks == 0 || SEL != last_sel) begin
                            if (passes < 16) begin
                                pfx[passes] = CAND_X; pfy[passes] = CAND_Y;
                                pxx[passes] = FIX_X;  pxy[passes] = FIX_Y;
                                pxe[passes] = FIX_EN;
                            end
                            passes++;
                        end
                        last_sel = SEL;
                        cur = passes - 1;
                        if (cur < 16) begin
                            pcnt[cur]++;
                            plx[cur] = CAND_X;
                            ply[cur] = CAND_Y;
                        end
                        CNT = CW'(stub(eng_mode, int'(SEL), int'(CAND_X),
                                       int'(CAND_Y), cur / 2));
                        ACK = 1'b1;
                        acks++;
                    end else begin
                        wait_left--;
                    end
                end else begin
                    if (have) begin
                        chk("req_dropped_early", 0, 1);
                        have = 0;
                    end
                    if (eng_spur != 0 && !RST) begin
                        ACK = 1'b1;
                        CNT = '1;
                    end
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, REQ, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_sel"}, SEL, 0);
        chk({tag, "_fixen"}, FIX_EN, 0);
        chk({tag, "_cand"}, {CAND_X, CAND_Y}, 0);
        chk({tag, "_c1"}, {C1X, C1Y}, 0);
        chk({tag, "_c2"}, {C2X, C2Y}, 0);
        chk({tag, "_best"}, BEST, 0);
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        vec_t e;
        bit   got;
        int   cyc;
        eng_mode = v.mode;
        eng_dly  = v.dly;
        eng_spur = v.spur;
        clear_stats();
        sb_q.push_back(v);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("prep_busy", BUSY, 1);
        chk("prep_req", REQ, 0);
        @(negedge CLK);
        chk("first_req", REQ, 1);
        chk("first_cand", {CAND_X, CAND_Y}, 0);
        chk("first_sel", SEL, 0);
        chk("first_fixen", FIX_EN, 0);
        got = 0;
        cyc = 0;
        while (!got && cyc < 20000) begin
            @(negedge CLK);
            START = (v.mode == 3 && cyc == 300) ? 1'b1 : 1'b0;
            if (DONE) got = 1;
            cyc++;
        end
        START = 1'b0;
        chk("done_seen", got, 1);
        e = sb_q.pop_front();
        if (got) begin
            chk("c1x", C1X, e.c1x);
            chk("c1y", C1Y, e.c1y);
            chk("c2x", C2X, e.c2x);
            chk("c2y", C2Y, e.c2y);
            chk("best", BEST, e.best);
            chk("busy_at_done", BUSY, 1);
            chk("ack_count", acks, e.acks);
            chk("pass_count", passes, e.passes);
            chk("pass0_cands", pcnt[0], 256);
            chk("gap_1cyc", gap1, e.acks - e.passes);
            chk("gap_3cyc", gap3, e.passes - 1);
            chk("gap_other", gapx, 0);
            chk("pass0_fixen", pxe[0], 0);
            chk("pass1_fixen", pxe[1], 1);
            if (v.mode == 1) begin
                chk("p2_cands", pcnt[2], 49);
                chk("p2_first", pfx[2] * 16 + pfy[2], 4 * 16 + 6);
                chk("p2_last", plx[2] * 16 + ply[2], 10 * 16 + 12);
                chk("p2_fix", pxx[2] * 16 + pxy[2], 3 * 16 + 12);
                chk("p3_cands", pcnt[3], 49);
                chk("p3_first", pfx[3] * 16 + pfy[3], 0 * 16 + 9);
                chk("p3_last", plx[3] * 16 + ply[3], 6 * 16 + 15);
                chk("p3_fix", pxx[3] * 16 + pxy[3], 7 * 16 + 9);
            end
            @(negedge CLK);
            chk("done_pulse", DONE, 0);
            chk("busy_fall", BUSY, 0);
            chk("hold_c1", {C1X, C1Y}, e.c1x * 16 + e.c1y);
            chk("hold_best", BEST, e.best);
        end else begin
            RST = 1'b1;
            @(negedge CLK);
            RST = 1'b0;
        end
        $display("run %0d mode=%0d dly=%0d acks=%0d passes=%0d c1=(%0d,%0d) c2=(%0d,%0d) best=%0d",
                 idx, v.mode, v.dly, acks, passes, C1X, C1Y, C2X, C2Y, BEST);
    endtask

    initial begin
        bit reached;
        int cyc;
        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 544, 4};
        vecs[1] = '{1, 0, 0, 7, 9, 3, 12, 30, 610, 4};
        vecs[2] = '{2, 0, 0, 2, 2, 0, 0, 0, 564, 4};
        vecs[3] = '{1, 2, 1, 7, 9, 3, 12, 30, 610, 4};
        vecs[4] = '{0, 1, 0, 0, 0, 0, 0, 0, 544, 4};
        vecs[5] = '{3, 0, 0, 0, 0, 0, 0, 32, 608, 8};

        RST   = 1'b1;
        START = 1'b0;
        repeat (3) @(negedge CLK);
        chk_zero("reset");
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk_zero("idle");

        for (int i = 0; i < 6; i++) begin
            run_vector(vecs[i], i);
        end

        // Asynchronous reset in the middle of the first pass.
        eng_mode = 1; eng_dly = 0; eng_spur = 0;
        clear_stats();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        reached = 0;
        cyc = 0;
        while (!reached && cyc < 2000) begin
            @(negedge CLK);
            if (acks >= 100) reached = 1;
            cyc++;
        end
        chk("ack100_seen", reached, 1);
        #2;
        chk("pre_rst_cand", {CAND_X, CAND_Y}, 8'h36);
        chk("pre_rst_busy", BUSY, 1);
        RST = 1'b1;
        #1;
        chk_zero("async_rst");
        $display("reset applied mid-pass after %0d acks", acks);
        @(negedge CLK);
        RST = 1'b0;
        run_vector(vecs[0], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
